// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: register address type,
// forwarding select encoding, scoreboard entry layout and scoreboard depth.
package hazard_pkg;

    localparam int ADDR_W   = 5;
    localparam int SB_DEPTH = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    // Forwarding source for a decode operand.
    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_EXE = 2'd1,
        SEL_MEM = 2'd2,
        SEL_REG = 2'd3
    } rs_t;

    // One in-flight producer: S0 = ALU, S1 = EXE, S2 = MEM.
    typedef struct packed {
        logic  valid;
        addr_t rd;
        logic  load;
    } sb_entry_t;

    // Youngest matching stage wins; no match reads the register file.
    function automatic rs_t sel_from_match(input logic [SB_DEPTH-1:0] m);
        rs_t sel;
        if (m[0])      sel = SEL_ALU;
        else if (m[1]) sel = SEL_EXE;
        else if (m[2]) sel = SEL_MEM;
        else           sel = SEL_REG;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-stage <-> hazard controller bundle. Decode (master) presents the
// instruction it holds; the hazard controller (slave) returns forwarding
// selects and the stall request.
interface hazard_if;
    import hazard_pkg::*;

    logic  advance;
    logic  id_valid;
    logic  flush;
    addr_t rs1_addr;
    addr_t rs2_addr;
    logic  rs1_used;
    logic  rs2_used;
    addr_t rd_addr;
    logic  rd_wr;
    logic  rd_load;
    rs_t   rs1_sel;
    rs_t   rs2_sel;
    logic  stall;

    modport master (
        output advance, id_valid, flush,
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        output rd_addr, rd_wr, rd_load,
        input  rs1_sel, rs2_sel, stall
    );

    modport slave (
        input  advance, id_valid, flush,
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  rd_addr, rd_wr, rd_load,
        output rs1_sel, rs2_sel, stall
    );

endinterface

// File: rtl/hazard_match.sv
// Compares one decode source register against every scoreboard entry and
// returns a per-stage match vector (bit k set = entry Sk produces this source).
// x0 and unused sources never match.
module hazard_match
    import hazard_pkg::*;
(
    input  addr_t                      addr_i,
    input  logic                       used_i,
    input  sb_entry_t [SB_DEPTH-1:0]   sb_i,
    output logic      [SB_DEPTH-1:0]   match_o
);

    // Per-stage address compare, gated by valid, use and non-zero address.
    always_comb begin
        match_o = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            match_o[k] = used_i && (addr_i != '0) && sb_i[k].valid && (sb_i[k].rd == addr_i);
        end
    end

endmodule

// File: rtl/hazard.sv
// Decode-stage pipeline hazard controller. Tracks destinations of the
// instructions in ALU/EXE/MEM and produces forwarding selects and a stall.
// Build option: HAZARD_FORWARD_EN -- when defined, results are forwarded from
// ALU/EXE/MEM and only load-use stalls; when undefined, selects are tied to
// REG and any dependency on an in-flight producer stalls until it leaves MEM.
module hazard
    import hazard_pkg::*;
(
    input  logic     aclk,
    input  logic     aresetn,
    hazard_if.slave  bus
);

    sb_entry_t [SB_DEPTH-1:0] sb_q;
    sb_entry_t [SB_DEPTH-1:0] sb_d;
    logic      [SB_DEPTH-1:0] m1;
    logic      [SB_DEPTH-1:0] m2;
    logic                     hazard_w;
    logic                     stall_w;
    logic                     issue_w;

    hazard_match u_match_rs1 (
        .addr_i  (bus.rs1_addr),
        .used_i  (bus.rs1_used),
        .sb_i    (sb_q),
        .match_o (m1)
    );

    hazard_match u_match_rs2 (
        .addr_i  (bus.rs2_addr),
        .used_i  (bus.rs2_used),
        .sb_i    (sb_q),
        .match_o (m2)
    );

`ifdef HAZARD_FORWARD_EN
    // A load result exists only at MEM, so a match on a load in ALU or EXE
    // cannot be forwarded yet.
    logic [1:0] ld_young;
    logic       unused_ld;
    assign ld_young  = {sb_q[1].load, sb_q[0].load};
    assign hazard_w  = |(m1[1:0] & ld_young) | |(m2[1:0] & ld_young);
    assign unused_ld = sb_q[2].load;

    assign bus.rs1_sel = sel_from_match(m1);
    assign bus.rs2_sel = sel_from_match(m2);
`else
    // Without forwarding the operand is only valid once the producer has
    // written the register file, i.e. after it leaves MEM.
    logic unused_ld;
    assign hazard_w  = |m1 | |m2;
    assign unused_ld = ^{sb_q[2].load, sb_q[1].load, sb_q[0].load};

    assign bus.rs1_sel = SEL_REG;
    assign bus.rs2_sel = SEL_REG;
`endif

    // A flushed instruction never stalls; flush wins over any hazard.
    assign stall_w   = bus.id_valid & ~bus.flush & hazard_w;
    assign bus.stall = stall_w;

    // Only real, non-squashed, non-stalled writers of a non-zero register enter S0.
    assign issue_w = bus.id_valid & bus.rd_wr & ~stall_w & ~bus.flush & (bus.rd_addr != '0);

    // Next scoreboard: shift down one stage when the pipeline advances, else hold.
    always_comb begin
        sb_d = sb_q;
        if (bus.advance) begin
            for (int k = SB_DEPTH - 1; k > 0; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[0].valid = issue_w;
            sb_d[0].rd    = bus.rd_addr;
            sb_d[0].load  = bus.rd_load;
        end
    end

    // Scoreboard register; reset only clears valid bits, payload is don't-care.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int k = 0; k < SB_DEPTH; k++) begin
                sb_q[k].valid <= 1'b0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: tb/tb_hazard.sv
// Testbench for the hazard controller: directed decode sequences followed by
// randomized traffic, checked through an expected-response queue against a
// model that keeps the last three instructions issued past decode.
module tb_hazard;
    import hazard_pkg::*;

    logic aclk;
    logic aresetn;

    hazard_if bus ();

    hazard dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Model: pipe[0] is the instruction now in ALU, pipe[1] EXE, pipe[2] MEM.
    typedef struct {
        bit          wr;
        int unsigned rd;
        bit          ld;
    } slot_t;

    typedef struct {
        rs_t s1;
        rs_t s2;
        bit  st;
        int  id;
    } exp_t;

    slot_t pipe[$];
    exp_t  sbq[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    n_step  = 0;

    // Age (0 = youngest) of the youngest producer of a source, or -1.
    function automatic int dist_of(input int unsigned a, input bit used);
        if (!used || a == 0) return -1;
        for (int k = 0; k < pipe.size() && k < 3; k++)
            if (pipe[k].wr && pipe[k].rd == a) return k;
        return -1;
    endfunction

    function automatic rs_t exp_sel(input int unsigned a, input bit used);
`ifdef HAZARD_FORWARD_EN
        case (dist_of(a, used))
            0:       return SEL_ALU;
            1:       return SEL_EXE;
            2:       return SEL_MEM;
            default: return SEL_REG;
        endcase
`else
        if (dist_of(a, used) >= -1) return SEL_REG;
        return SEL_REG;
`endif
    endfunction

    // Does this source have to wait for some in-flight producer?
    function automatic bit exp_wait(input int unsigned a, input bit used);
        if (!used || a == 0) return 1'b0;
        for (int k = 0; k < pipe.size() && k < 3; k++) begin
            if (pipe[k].wr && pipe[k].rd == a) begin
`ifdef HAZARD_FORWARD_EN
                if (k < 2 && pipe[k].ld) return 1'b1;
`else
                return 1'b1;
`endif
            end
        end
        return 1'b0;
    endfunction

    // One decode cycle: drive, predict, then let the clock edge move the model.
    task automatic step(input bit rstn, input bit adv, input bit idv, input bit fl,
                        input int unsigned r1, input bit u1,
                        input int unsigned r2, input bit u2,
                        input int unsigned rd, input bit wr, input bit ld,
                        output bit st);
        exp_t  e;
        slot_t s;
        aresetn      = rstn;
        bus.advance  = adv;
        bus.id_valid = idv;
        bus.flush    = fl;
        bus.rs1_addr = addr_t'(r1);
        bus.rs1_used = u1;
        bus.rs2_addr = addr_t'(r2);
        bus.rs2_used = u2;
        bus.rd_addr  = addr_t'(rd);
        bus.rd_wr    = wr;
        bus.rd_load  = ld;
        e.s1 = exp_sel(r1, u1);
        e.s2 = exp_sel(r2, u2);
        e.st = idv && !fl && (exp_wait(r1, u1) || exp_wait(r2, u2));
        e.id = n_step;
        n_step++;
        sbq.push_back(e);
        st = e.st;
        @(posedge aclk);
        if (!rstn) begin
            pipe.delete();
        end else if (adv) begin
            s.wr = idv && wr && !e.st && !fl && rd != 0;
            s.rd = rd;
            s.ld = ld;
            pipe.push_front(s);
            if (pipe.size() > 3) void'(pipe.pop_back());
        end
        #1;
    endtask

    // Present an instruction until decode accepts it (bounded).
    task automatic issue(input int unsigned r1, input bit u1, input int unsigned r2,
                         input bit u2, input int unsigned rd, input bit wr, input bit ld);
        bit st;
        int n;
        n = 0;
        do begin
            step(1, 1, 1, 0, r1, u1, r2, u2, rd, wr, ld, st);
            n++;
        end while (st && n < 8);
    endtask

    task automatic bubbles(input int n);
        bit st;
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    // Monitor: outputs are combinational, so every cycle with a prediction is checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_total++;
                if (bus.rs1_sel !== e.s1 || bus.rs2_sel !== e.s2 || bus.stall !== e.st) begin
                    n_bad++;
                    $display("FAIL sel_stall cyc=%0d got rs1=%0d rs2=%0d stall=%0b want rs1=%0d rs2=%0d stall=%0b",
                             e.id, int'(bus.rs1_sel), int'(bus.rs2_sel), bus.stall,
                             int'(e.s1), int'(e.s2), e.st);
                end
            end
        end
    end

    initial begin
        bit st;
        int wait_n;
        aresetn      = 1'b0;
        bus.advance  = 1'b0;
        bus.id_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.rs1_addr = '0;
        bus.rs1_used = 1'b0;
        bus.rs2_addr = '0;
        bus.rs2_used = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_wr    = 1'b0;
        bus.rd_load  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        pipe.delete();

        // Back-to-back dependency: add x5 ; sub x6,x5,x5
        issue(1, 1, 2, 1, 5, 1, 0);
        issue(5, 1, 5, 1, 6, 1, 0);
        bubbles(3);
        // Distance 2 and distance 3 on x5
        issue(1, 1, 2, 1, 5, 1, 0);
        issue(1, 1, 1, 1, 9, 1, 0);
        issue(5, 1, 3, 1, 10, 1, 0);
        bubbles(3);
        issue(1, 1, 2, 1, 5, 1, 0);
        issue(1, 1, 1, 1, 9, 1, 0);
        issue(2, 1, 2, 1, 11, 1, 0);
        issue(3, 1, 5, 1, 12, 1, 0);
        bubbles(3);
        // Two producers of x5 in flight, youngest must win
        issue(1, 1, 2, 1, 5, 1, 0);
        issue(1, 1, 1, 1, 11, 1, 0);
        issue(2, 1, 2, 1, 5, 1, 0);
        issue(5, 1, 5, 1, 13, 1, 0);
        bubbles(3);
        // Load-use: lw x7 ; add x8,x7,x1
        issue(1, 1, 0, 0, 7, 1, 1);
        issue(7, 1, 1, 1, 8, 1, 0);
        bubbles(3);
        // x0 producer and consumer, then unused rs2 matching a producer
        issue(1, 1, 2, 1, 0, 1, 0);
        issue(0, 1, 0, 1, 14, 1, 0);
        issue(1, 1, 2, 1, 5, 1, 0);
        issue(1, 1, 5, 0, 15, 1, 0);
        bubbles(3);
        // Back-pressure during a load-use stall, then flush the consumer
        issue(1, 1, 0, 0, 7, 1, 1);
        step(1, 1, 1, 0, 7, 1, 1, 1, 8, 1, 0, st);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 7, 1, 1, 1, 8, 1, 0, st);
        step(1, 1, 1, 1, 7, 1, 1, 1, 8, 1, 0, st);
        step(1, 1, 1, 0, 7, 1, 2, 1, 16, 1, 0, st);
        bubbles(3);
        // Reset in the middle of a stall
        issue(1, 1, 0, 0, 9, 1, 1);
        step(1, 1, 1, 0, 9, 1, 9, 1, 17, 1, 0, st);
        step(0, 1, 1, 0, 9, 1, 9, 1, 17, 1, 0, st);
        step(1, 1, 1, 0, 9, 1, 9, 1, 17, 1, 0, st);
        bubbles(3);

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3), $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, st);
        end

        wait_n = 0;
        while (sbq.size() > 0 && wait_n < 10) begin
            @(posedge aclk);
            wait_n++;
        end
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
